game_sequencer: RTL

- Central game-flow controller for the Space Invaders datapath.
- Sequences the playfield through attract, wave load, play, respawn, wave-clear and game-over phases.
- Derives frame ticks from the VGA vertical sync and paces alien marching, speeding it up each wave.
- Owns score, lives and wave. The score feeds the seven-segment display; the control pulses feed the sprite/bitchange logic.

---
 rtl/game_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/game_sequencer.sv
// Game-flow controller for the Space Invaders datapath: sequences attract,
// wave load, play, respawn, wave-clear and game-over phases, paces alien
// marching from VGA frame ticks, and owns score, lives and wave.
module game_sequencer #(
  parameter int INIT_STEP_FRAMES = 30,
  parameter int STEP_DEC         = 4,
  parameter int MIN_STEP_FRAMES  = 6,
  parameter int START_LIVES      = 3,
  parameter int POINTS_PER_ALIEN = 10,
  parameter int SCORE_MAX        = 9999,
  parameter int RESPAWN_FRAMES   = 90,
  parameter int CLEAR_FRAMES     = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vSync,
  input  logic        start_btn,
  input  logic        alien_hit,
  input  logic        player_hit,
  input  logic        aliens_zero,
  input  logic        invasion,
  output logic [2:0]  state,
  output logic [15:0] score,
  output logic [1:0]  lives,
  output logic [3:0]  wave,
  output logic        alien_step,
  output logic        load_wave,
  output logic        game_active
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_LOAD       = 3'd1;
  localparam logic [2:0] S_PLAY       = 3'd2;
  localparam logic [2:0] S_RESPAWN    = 3'd3;
  localparam logic [2:0] S_WAVE_CLEAR = 3'd4;
  localparam logic [2:0] S_GAME_OVER  = 3'd5;

  logic       vsync_q;
  logic       frame_tick;
  logic       start_q;
  logic       start_armed;
  logic       start_rise;
  logic [7:0] frame_cnt;
  logic [7:0] step_period;
  logic [7:0] phase_cnt;
  logic [2:0] state_next;
  logic       phase_done_resp;
  logic       phase_done_clear;

  // Step period for a wave, clamped at the floor in signed arithmetic so a
  // large wave number can never wrap the period around to a huge value.
  function automatic logic [7:0] calc_period(input logic [3:0] w);
    int dec;
    int raw;
    dec = (w == 4'd0) ? 0 : (int'(w) - 1) * STEP_DEC;
    raw = INIT_STEP_FRAMES - dec;
    if (raw < MIN_STEP_FRAMES) raw = MIN_STEP_FRAMES;
    return 8'(raw);
  endfunction

  // start_armed only sets once the button has been seen released after reset,
  // so a button held through reset cannot look like a fresh press.
  assign start_rise = start_btn & ~start_q & start_armed;

  assign phase_done_resp  = frame_tick && (phase_cnt == 8'(RESPAWN_FRAMES - 1));
  assign phase_done_clear = frame_tick && (phase_cnt == 8'(CLEAR_FRAMES - 1));

  // Step pulse lands on the very frame tick that completes the step period.
  assign alien_step = (state == S_PLAY) && frame_tick &&
                      (frame_cnt == step_period - 8'd1);

  // Next-state selection, including the PLAY exit priority.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:       if (start_rise) state_next = S_LOAD;
      S_LOAD:       state_next = S_PLAY;
      S_PLAY: begin
        if (invasion)         state_next = S_GAME_OVER;
        else if (player_hit)  state_next = (lives <= 2'd1) ? S_GAME_OVER : S_RESPAWN;
        else if (aliens_zero) state_next = S_WAVE_CLEAR;
      end
      S_RESPAWN:    if (phase_done_resp) state_next = S_PLAY;
      S_WAVE_CLEAR: if (phase_done_clear) state_next = S_LOAD;
      S_GAME_OVER:  if (start_rise) state_next = S_LOAD;
      default:      state_next = S_IDLE;
    endcase
  end

  // State, edge detectors, counters and game registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      score       <= '0;
      lives       <= '0;
      wave        <= '0;
      load_wave   <= 1'b0;
      game_active <= 1'b0;
      vsync_q     <= 1'b1;
      frame_tick  <= 1'b0;
      start_q     <= 1'b0;
      start_armed <= 1'b0;
      frame_cnt   <= '0;
      step_period <= 8'(INIT_STEP_FRAMES);
      phase_cnt   <= '0;
    end else begin
      state       <= state_next;
      load_wave   <= (state_next == S_LOAD);
      game_active <= (state_next == S_PLAY);
      vsync_q     <= vSync;
      frame_tick  <= vsync_q & ~vSync;
      start_q     <= start_btn;
      if (!start_btn) start_armed <= 1'b1;

      case (state)
        S_IDLE, S_GAME_OVER: begin
          if (start_rise) begin
            score <= '0;
            lives <= 2'(START_LIVES);
            wave  <= 4'd1;
          end
        end
        S_LOAD: begin
          step_period <= calc_period(wave);
          frame_cnt   <= '0;
        end
        S_PLAY: begin
          phase_cnt <= '0;
          if (frame_tick) frame_cnt <= alien_step ? 8'd0 : frame_cnt + 8'd1;
          if (alien_hit) begin
            if (score >= 16'(SCORE_MAX - POINTS_PER_ALIEN)) score <= 16'(SCORE_MAX);
            else score <= score + 16'(POINTS_PER_ALIEN);
          end
          if (invasion)                       lives <= '0;
          else if (player_hit && lives != '0) lives <= lives - 2'd1;
        end
        S_RESPAWN: begin
          if (frame_tick) phase_cnt <= phase_done_resp ? 8'd0 : phase_cnt + 8'd1;
        end
        S_WAVE_CLEAR: begin
          if (frame_tick) begin
            if (phase_done_clear) begin
              phase_cnt <= '0;
              if (wave != 4'd15) wave <= wave + 4'd1;
            end else begin
              phase_cnt <= phase_cnt + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
